bg_scroll_ctrl: RTL
===================

Name: bg_scroll_ctrl

Overview:
Game-state sequencer for the scrolling background datapath. It owns the run/pause/game-over FSM and advances the background scroll origin once per video frame at a speed that ramps with distance. It drives the pos_x/pos_y inputs of the background address generator and publishes state and score to the top level. Sits between the debounced button/collision logic and the background renderer.

Parameters:
BG_WIDTH, 320, horizontal period of background image in pixels; xpos range 0..BG_WIDTH-1
Y_ORIGIN, 240, constant ypos value
INIT_SPEED, 1, pixels per frame after start
MAX_SPEED, 8, speed saturation value
RAMP_FRAMES, 600, RUN frames between speed increments
SCORE_MAX, 9999, score saturation value

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
frame_tick  input  1  level signal, high during vertical blank; rising edge = new frame
start_btn  input  1  debounced level; rising edge = start/restart
pause_btn  input  1  debounced level; rising edge = pause toggle
collision  input  1  level; sampled only in RUN
xpos  output  9  background scroll x origin
ypos  output  9  background scroll y origin, always Y_ORIGIN
speed  output  4  current pixels per frame
game_state  output  2  IDLE=0, RUN=1, PAUSE=2, OVER=3
step  output  1  one-clk pulse on every frame where xpos advanced
score  output  14  frames survived in current run, saturating
night  output  1  day/night flag (see Optional Feature)

Behaviour:
- All input edges detected by registered rising-edge detection; resulting pulse is 1 clk wide, 1 clk after the input edge (1 clk latency).
- Reset values: game_state=IDLE, xpos=0, ypos=Y_ORIGIN, speed=INIT_SPEED, step=0, score=0, night=0, ramp counter=0. Reset mid-run discards all state.
- FSM transitions, evaluated on edge pulses:
  - IDLE -> RUN on start. Loads speed=INIT_SPEED, score=0, ramp counter=0; xpos keeps its value.
  - RUN -> OVER when collision=1, checked every clk.
  - RUN -> PAUSE on pause.
  - PAUSE -> RUN on pause.
  - OVER -> IDLE on start. xpos and score are held until the next IDLE->RUN.
  - start in RUN or PAUSE: ignored. pause in IDLE or OVER: ignored.
- Priority within one clk: collision > pause > frame. If collision and pause coincide in RUN, the result is OVER.
- Frame update, only in RUN on a frame pulse with no collision that clk:
  - xpos_next = (xpos >= speed) ? xpos - speed : xpos + BG_WIDTH - speed. Computed at 10-bit width, result always < BG_WIDTH.
  - step=1 for that single clk.
  - score increments, saturating at SCORE_MAX.
  - ramp counter increments. On reaching RAMP_FRAMES-1 it wraps to 0 and speed increments, saturating at MAX_SPEED. The new speed applies from the next frame.
- PAUSE, IDLE and OVER: xpos, speed, score and ramp counter all frozen; step=0.
- Outputs are registered. xpos changes at most once per frame and only on the clk following the frame-pulse detection, i.e. during vertical blank, so no tearing.

Optional Feature:
- Macro NIGHT_MODE_EN.
- Defined: night toggles each time score crosses a multiple of 700 (700, 1400, …) while in RUN; cleared on IDLE->RUN and on reset.
- Undefined: night tied to 0 and no comparator logic is generated.

Decomposition:
- Package bg_ctrl_pkg holds:
  - game_state encodings IDLE/RUN/PAUSE/OVER as localparams/typedef
  - default BG_WIDTH and Y_ORIGIN
  - the night period constant 700
- One sub-module, edge_pulse: registered rising-edge detector with async active-high reset. Instantiated three times, for frame_tick, start_btn and pause_btn.

Test Plan:
- Reset held, then released -> xpos=0, ypos=240, speed=1, game_state=0, step=0. Assert rst mid-RUN -> all outputs return to these values immediately (async).
- start edge then 5 frame edges -> game_state=1, xpos sequence 319,318,317,316,315, five single-clk step pulses, score=5.
- Wrap at speed=3: force xpos=1, then one frame -> xpos=318 (1+320-3). With xpos=3 -> 0.
- RAMP_FRAMES=4: run 12 frames -> speed=1,1,1,1,2,2,2,2,3,… Speed saturates at MAX_SPEED=8 and never reaches 9.
- Pause edge in RUN, then 3 frames -> xpos/score unchanged, step=0. Second pause -> resumes. Collision and pause in the same clk -> game_state=3.
- OVER, then start -> IDLE with score held. Second start -> RUN, score=0, speed=1. With NIGHT_MODE_EN, score reaching 700 -> night=1.

Source files
------------

// File: rtl/bg_scroll_ctrl_pkg.sv
// Shared definitions for the scrolling-background game sequencer.
// This package holds the game state encoding, the default image geometry
// and the day/night period.
package bg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int DEF_BG_WIDTH = 320;
    localparam int DEF_Y_ORIGIN = 240;
    localparam int NIGHT_PERIOD = 700;

    // Returns true when a freshly reached score lands on a day/night boundary.
    function automatic logic is_night_boundary(input logic [13:0] score);
        return (score != 14'd0) && ((score % 14'(NIGHT_PERIOD)) == 14'd0);
    endfunction

endpackage

// File: rtl/bg_scroll_ctrl_if.sv
// Bundle of the button/collision inputs and renderer-facing outputs of the
// background scroll controller. The slave modport is the controller side and
// the master modport is the side that drives the buttons and reads the outputs.
interface bg_scroll_ctrl_if;
    import bg_ctrl_pkg::*;

    logic        i_frame_tick;
    logic        i_start_btn;
    logic        i_pause_btn;
    logic        i_collision;
    logic [8:0]  o_xpos;
    logic [8:0]  o_ypos;
    logic [3:0]  o_speed;
    game_state_t o_game_state;
    logic        o_step;
    logic [13:0] o_score;
    logic        o_night;

    modport master (
        output i_frame_tick, i_start_btn, i_pause_btn, i_collision,
        input  o_xpos, o_ypos, o_speed, o_game_state, o_step, o_score, o_night
    );

    modport slave (
        input  i_frame_tick, i_start_btn, i_pause_btn, i_collision,
        output o_xpos, o_ypos, o_speed, o_game_state, o_step, o_score, o_night
    );
endinterface

// File: rtl/bg_scroll_ctrl_edge_pulse.sv
// Registered rising-edge detector. The output pulse is exactly one clock
// wide and appears one clock after the input level rises.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    // Remember the previous level and register the rise as a one-clock pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/bg_scroll_ctrl.sv
// Game-state sequencer for the scrolling background: run/pause/game-over FSM,
// per-frame scroll origin update with a distance-based speed ramp, and score.
// Optional feature macro: NIGHT_MODE_EN (day/night flag toggling every
// NIGHT_PERIOD points of score). Without it o_night is tied low.
module bg_scroll_ctrl
    import bg_ctrl_pkg::*;
#(
    parameter int BG_WIDTH    = DEF_BG_WIDTH,
    parameter int Y_ORIGIN    = DEF_Y_ORIGIN,
    parameter int INIT_SPEED  = 1,
    parameter int MAX_SPEED   = 8,
    parameter int RAMP_FRAMES = 600,
    parameter int SCORE_MAX   = 9999
) (
    input  logic            clk,
    input  logic            rst,
    bg_scroll_ctrl_if.slave bus
);

    localparam int RAMP_W = $clog2(RAMP_FRAMES + 1);

    logic w_frame;
    logic w_start;
    logic w_pause;

    game_state_t r_state, w_state_next;
    logic [8:0]        r_xpos, w_xpos_next;
    logic [3:0]        r_speed, w_speed_next;
    logic [13:0]       r_score, w_score_next;
    logic [RAMP_W-1:0] r_ramp, w_ramp_next;
    logic              r_step, w_step_next;
    logic              w_run_start;

    logic [9:0]  w_xpos_sub;
    logic [8:0]  w_xpos_wrap;
    logic [8:0]  w_xpos_adv;
    logic [13:0] w_score_inc;

    edge_pulse u_frame_edge (.clk(clk), .rst(rst), .i_level(bus.i_frame_tick), .o_pulse(w_frame));
    edge_pulse u_start_edge (.clk(clk), .rst(rst), .i_level(bus.i_start_btn),  .o_pulse(w_start));
    edge_pulse u_pause_edge (.clk(clk), .rst(rst), .i_level(bus.i_pause_btn),  .o_pulse(w_pause));

    // The 10-bit difference borrows into bit 9 exactly when speed exceeds xpos;
    // in that case adding the image width modulo 512 lands back in 0..BG_WIDTH-1.
    assign w_xpos_sub  = {1'b0, r_xpos} - 10'(r_speed);
    assign w_xpos_wrap = w_xpos_sub[8:0] + 9'(BG_WIDTH);
    assign w_xpos_adv  = w_xpos_sub[9] ? w_xpos_wrap : w_xpos_sub[8:0];
    assign w_score_inc = (r_score == 14'(SCORE_MAX)) ? r_score : r_score + 14'd1;

    // Next-state and next-value logic; collision beats pause, pause beats frame.
    always_comb begin
        w_state_next = r_state;
        w_xpos_next  = r_xpos;
        w_speed_next = r_speed;
        w_score_next = r_score;
        w_ramp_next  = r_ramp;
        w_step_next  = 1'b0;
        w_run_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_RUN;
                    w_speed_next = 4'(INIT_SPEED);
                    w_score_next = '0;
                    w_ramp_next  = '0;
                    w_run_start  = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.i_collision) begin
                    w_state_next = ST_OVER;
                end else if (w_pause) begin
                    w_state_next = ST_PAUSE;
                end else if (w_frame) begin
                    w_xpos_next  = w_xpos_adv;
                    w_step_next  = 1'b1;
                    w_score_next = w_score_inc;
                    if (r_ramp == RAMP_W'(RAMP_FRAMES - 1)) begin
                        w_ramp_next = '0;
                        if (r_speed < 4'(MAX_SPEED)) begin
                            w_speed_next = r_speed + 4'd1;
                        end
                    end else begin
                        w_ramp_next = r_ramp + RAMP_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (w_pause) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_OVER: begin
                if (w_start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards the whole run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_xpos  <= '0;
            r_speed <= 4'(INIT_SPEED);
            r_score <= '0;
            r_ramp  <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_xpos  <= w_xpos_next;
            r_speed <= w_speed_next;
            r_score <= w_score_next;
            r_ramp  <= w_ramp_next;
            r_step  <= w_step_next;
        end
    end

`ifdef NIGHT_MODE_EN
    logic r_night;

    // Flip day/night whenever an advancing frame lands the score on a new period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_night <= 1'b0;
        end else if (w_run_start) begin
            r_night <= 1'b0;
        end else if (w_step_next && (w_score_inc != r_score) && is_night_boundary(w_score_inc)) begin
            r_night <= ~r_night;
        end
    end

    assign bus.o_night = r_night;
`else
    assign bus.o_night = 1'b0;
`endif

    assign bus.o_xpos       = r_xpos;
    assign bus.o_ypos       = 9'(Y_ORIGIN);
    assign bus.o_speed      = r_speed;
    assign bus.o_game_state = r_state;
    assign bus.o_step       = r_step;
    assign bus.o_score      = r_score;

endmodule
